// File: rtl/conv_mem_responder.sv
// Memory/host-side responder for the CONV accelerator: image source, five result banks,
// and the ready/busy run handshake with sticky protocol error flags.
module conv_mem_responder #(
  parameter int DATAW   = 20,
  parameter int ADDRW   = 12,
  parameter int TIMEOUT = 1024
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_en,
  input  logic [ADDRW-1:0] load_addr,
  input  logic [DATAW-1:0] load_data,
  input  logic             start,
  output logic             ready,
  input  logic             busy,
  input  logic [ADDRW-1:0] iaddr,
  output logic [DATAW-1:0] idata,
  input  logic [2:0]       csel,
  input  logic             cwr,
  input  logic [ADDRW-1:0] caddr_wr,
  input  logic [DATAW-1:0] cdata_wr,
  input  logic             crd,
  input  logic [ADDRW-1:0] caddr_rd,
  output logic [DATAW-1:0] cdata_rd,
  output logic             done,
  output logic             err_sel,
  output logic             err_addr,
  output logic             err_timeout,
  input  logic [2:0]       dbg_sel,
  input  logic [ADDRW-1:0] dbg_addr,
  output logic [DATAW-1:0] dbg_data
);

  localparam int TW = $clog2(TIMEOUT + 1);

  localparam logic [2:0] SEL_L0K0 = 3'd1;
  localparam logic [2:0] SEL_L0K1 = 3'd2;
  localparam logic [2:0] SEL_L1K0 = 3'd3;
  localparam logic [2:0] SEL_L1K1 = 3'd4;
  localparam logic [2:0] SEL_L2   = 3'd5;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARM,
    S_RUN,
    S_DONE
  } state_t;

  // Word count of each bank; zero marks an unmapped select code.
  function automatic logic [ADDRW:0] bank_depth(input logic [2:0] sel);
    case (sel)
      SEL_L0K0, SEL_L0K1: bank_depth = (ADDRW+1)'(4096);
      SEL_L1K0, SEL_L1K1: bank_depth = (ADDRW+1)'(1024);
      SEL_L2:             bank_depth = (ADDRW+1)'(2048);
      default:            bank_depth = '0;
    endcase
  endfunction

  function automatic logic sel_valid(input logic [2:0] sel);
    sel_valid = (sel >= SEL_L0K0) && (sel <= SEL_L2);
  endfunction

  logic [DATAW-1:0] r_img  [0:4095];
  logic [DATAW-1:0] r_l0k0 [0:4095];
  logic [DATAW-1:0] r_l0k1 [0:4095];
  logic [DATAW-1:0] r_l1k0 [0:1023];
  logic [DATAW-1:0] r_l1k1 [0:1023];
  logic [DATAW-1:0] r_l2   [0:2047];

  state_t           r_state;
  logic [TW-1:0]    r_timer;
  logic             r_ready;
  logic             r_done;
  logic             r_err_sel;
  logic             r_err_addr;
  logic             r_err_timeout;
  logic [DATAW-1:0] r_rd_q;
  logic [DATAW-1:0] r_idata;
  logic [DATAW-1:0] r_cdata_rd;

  logic             w_wr_sel_ok;
  logic             w_wr_addr_ok;
  logic             w_wr_en;
  logic             w_rd_sel_ok;
  logic             w_rd_addr_ok;
  logic [DATAW-1:0] w_rd_word;
  logic             w_dbg_ok;

  assign w_wr_sel_ok  = sel_valid(csel);
  assign w_wr_addr_ok = {1'b0, caddr_wr} < bank_depth(csel);
  assign w_wr_en      = cwr && w_wr_sel_ok && w_wr_addr_ok;
  assign w_rd_sel_ok  = sel_valid(csel);
  assign w_rd_addr_ok = {1'b0, caddr_rd} < bank_depth(csel);
  assign w_dbg_ok     = sel_valid(dbg_sel) && ({1'b0, dbg_addr} < bank_depth(dbg_sel));

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    w_rd_word = '0;
    if (w_rd_sel_ok && w_rd_addr_ok) begin
      case (csel)
        SEL_L0K0: w_rd_word = r_l0k0[caddr_rd];
        SEL_L0K1: w_rd_word = r_l0k1[caddr_rd];
        SEL_L1K0: w_rd_word = r_l1k0[caddr_rd[9:0]];
        SEL_L1K1: w_rd_word = r_l1k1[caddr_rd[9:0]];
        SEL_L2:   w_rd_word = r_l2[caddr_rd[10:0]];
        default:  w_rd_word = '0;
      endcase
    end
  end

  always_comb begin
    dbg_data = '0;
    if (w_dbg_ok) begin
      case (dbg_sel)
        SEL_L0K0: dbg_data = r_l0k0[dbg_addr];
        SEL_L0K1: dbg_data = r_l0k1[dbg_addr];
        SEL_L1K0: dbg_data = r_l1k0[dbg_addr[9:0]];
        SEL_L1K1: dbg_data = r_l1k1[dbg_addr[9:0]];
        SEL_L2:   dbg_data = r_l2[dbg_addr[10:0]];
        default:  dbg_data = '0;
      endcase
    end
  end

  // Run handshake: ready is held from start until busy is seen or the arm timer expires.
  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state       <= S_IDLE;
      r_ready       <= 1'b0;
      r_done        <= 1'b0;
      r_timer       <= '0;
      r_err_timeout <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state <= S_ARM;
            r_ready <= 1'b1;
            r_timer <= '0;
          end
        end
        S_ARM: begin
          if (busy) begin
            r_state <= S_RUN;
            r_ready <= 1'b0;
          end else if (r_timer == TW'(TIMEOUT - 1)) begin
            r_state       <= S_IDLE;
            r_ready       <= 1'b0;
            r_err_timeout <= 1'b1;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        S_RUN: begin
          r_ready <= 1'b0;
          if (!busy) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
          r_ready <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_err_sel  <= 1'b0;
      r_err_addr <= 1'b0;
    end else begin
      if ((cwr && !w_wr_sel_ok) || (crd && !w_rd_sel_ok))
        r_err_sel <= 1'b1;
      if ((cwr && w_wr_sel_ok && !w_wr_addr_ok) || (crd && w_rd_sel_ok && !w_rd_addr_ok))
        r_err_addr <= 1'b1;
    end
  end

  // Read capture sees the pre-write word when cwr hits the same address this edge.
  always_ff @(posedge clk) begin
    if (!reset)
      r_rd_q <= '0;
    else if (crd)
      r_rd_q <= w_rd_word;
  end

  // NOTE: storage arrays have no reset; contents must survive reset and a clear would cost a port per word.
  always_ff @(posedge clk) begin
    if (r_state == S_IDLE && load_en)
      r_img[load_addr] <= load_data;
    if (w_wr_en) begin
      case (csel)
        SEL_L0K0: r_l0k0[caddr_wr]        <= cdata_wr;
        SEL_L0K1: r_l0k1[caddr_wr]        <= cdata_wr;
        SEL_L1K0: r_l1k0[caddr_wr[9:0]]   <= cdata_wr;
        SEL_L1K1: r_l1k1[caddr_wr[9:0]]   <= cdata_wr;
        SEL_L2:   r_l2[caddr_wr[10:0]]    <= cdata_wr;
        default: ;
      endcase
    end
  end

  // Accelerator-facing data is launched half a cycle ahead of its posedge sampling.
  always_ff @(negedge clk) begin
    if (!reset) begin
      r_idata    <= '0;
      r_cdata_rd <= '0;
    end else begin
      r_idata    <= r_img[iaddr];
      r_cdata_rd <= r_rd_q;
    end
  end

  assign ready       = r_ready;
  assign done        = r_done;
  assign idata       = r_idata;
  assign cdata_rd    = r_cdata_rd;
  assign err_sel     = r_err_sel;
  assign err_addr    = r_err_addr;
  assign err_timeout = r_err_timeout;

endmodule

// File: tb/tb_conv_mem_responder.sv
// Directed bench for conv_mem_responder: vector tables for image and bank traffic,
// hand-written sequences for the handshake, timeout, error and reset corner cases.
module tb_conv_mem_responder;

  localparam int DATAW   = 20;
  localparam int ADDRW   = 12;
  localparam int TIMEOUT = 1024;

  logic             clk = 1'b0;
  logic             reset;
  logic             load_en;
  logic [ADDRW-1:0] load_addr;
  logic [DATAW-1:0] load_data;
  logic             start;
  logic             ready;
  logic             busy;
  logic [ADDRW-1:0] iaddr;
  logic [DATAW-1:0] idata;
  logic [2:0]       csel;
  logic             cwr;
  logic [ADDRW-1:0] caddr_wr;
  logic [DATAW-1:0] cdata_wr;
  logic             crd;
  logic [ADDRW-1:0] caddr_rd;
  logic [DATAW-1:0] cdata_rd;
  logic             done;
  logic             err_sel;
  logic             err_addr;
  logic             err_timeout;
  logic [2:0]       dbg_sel;
  logic [ADDRW-1:0] dbg_addr;
  logic [DATAW-1:0] dbg_data;

  conv_mem_responder #(.DATAW(DATAW), .ADDRW(ADDRW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
    .start(start), .ready(ready), .busy(busy),
    .iaddr(iaddr), .idata(idata),
    .csel(csel), .cwr(cwr), .caddr_wr(caddr_wr), .cdata_wr(cdata_wr),
    .crd(crd), .caddr_rd(caddr_rd), .cdata_rd(cdata_rd),
    .done(done), .err_sel(err_sel), .err_addr(err_addr), .err_timeout(err_timeout),
    .dbg_sel(dbg_sel), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]       sel;
    logic [ADDRW-1:0] addr;
    logic [DATAW-1:0] data;
    logic [DATAW-1:0] exp;
  } bank_vec_t;

  typedef struct {
    logic [ADDRW-1:0] addr;
    logic [DATAW-1:0] exp;
  } img_vec_t;

  bank_vec_t bvec [8];
  img_vec_t  ivec [4];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual === expected)
      n_pass++;
    else
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  task automatic bank_write(input logic [2:0] s, input logic [ADDRW-1:0] a, input logic [DATAW-1:0] d);
    csel     = s;
    caddr_wr = a;
    cdata_wr = d;
    cwr      = 1'b1;
    cyc();
    cwr      = 1'b0;
  endtask

  task automatic bank_read(input logic [2:0] s, input logic [ADDRW-1:0] a, output logic [DATAW-1:0] q);
    csel     = s;
    caddr_rd = a;
    crd      = 1'b1;
    cyc();
    crd      = 1'b0;
    @(negedge clk);
    #1;
    q = cdata_rd;
  endtask

  task automatic dbg_check(input string name, input logic [2:0] s, input logic [ADDRW-1:0] a,
                           input logic [DATAW-1:0] e);
    dbg_sel  = s;
    dbg_addr = a;
    #1;
    check(name, dbg_data, e);
  endtask

  initial begin
    logic [DATAW-1:0] q;
    int pulses;

    bvec[0] = '{3'd1, 12'd0,    20'h00001, 20'h00001};
    bvec[1] = '{3'd1, 12'd4095, 20'hFFFFF, 20'hFFFFF};
    bvec[2] = '{3'd2, 12'd4095, 20'h0F0F0, 20'h0F0F0};
    bvec[3] = '{3'd2, 12'd100,  20'hABCDE, 20'hABCDE};
    bvec[4] = '{3'd3, 12'd1023, 20'h12345, 20'h12345};
    bvec[5] = '{3'd3, 12'd0,    20'h00ABC, 20'h00ABC};
    bvec[6] = '{3'd4, 12'd1023, 20'h54321, 20'h54321};
    bvec[7] = '{3'd5, 12'd2047, 20'h7A5A5, 20'h7A5A5};

    ivec[0] = '{12'd0,    20'd0};
    ivec[1] = '{12'd1,    20'd1};
    ivec[2] = '{12'd2730, 20'd2730};
    ivec[3] = '{12'd4095, 20'd4095};

    reset = 1'b0; load_en = 1'b0; load_addr = '0; load_data = '0; start = 1'b0;
    busy = 1'b0; iaddr = '0; csel = '0; cwr = 1'b0; caddr_wr = '0; cdata_wr = '0;
    crd = 1'b0; caddr_rd = '0; dbg_sel = '0; dbg_addr = '0;

    repeat (3) cyc();
    check("reset_ready", ready, 0);
    check("reset_done", done, 0);
    check("reset_idata", idata, 0);
    check("reset_cdata_rd", cdata_rd, 0);
    check("reset_errs", {err_sel, err_addr, err_timeout}, 0);
    reset = 1'b1;
    cyc();

    // Image preload IMG[i] = i, then read back through the negedge port.
    for (int i = 0; i < 4096; i++) begin
      load_en   = 1'b1;
      load_addr = ADDRW'(i);
      load_data = DATAW'(i);
      cyc();
    end
    load_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      iaddr = ivec[i].addr;
      @(negedge clk);
      #1;
      check($sformatf("img_%0d", ivec[i].addr), idata, ivec[i].exp);
    end

    // Handshake: ready high four cycles, falls the cycle after busy is seen.
    cyc();
    pulse_start();
    check("arm_ready_0", ready, 1);
    for (int k = 1; k <= 3; k++) begin
      cyc();
      check($sformatf("arm_ready_%0d", k), ready, 1);
    end
    busy = 1'b1;
    cyc();
    check("run_ready_low", ready, 0);
    pulse_start();
    check("start_in_run_ignored", ready, 0);
    check("run_no_done", done, 0);
    busy = 1'b0;
    cyc();
    check("done_pulse", done, 1);
    cyc();
    check("done_one_cycle", done, 0);
    pulse_start();
    check("rearm_ready", ready, 1);
    busy = 1'b1;
    cyc();
    busy = 1'b0;
    cyc();
    check("rearm_done", done, 1);
    cyc();
    check("rearm_done_clear", done, 0);

    // Bank vectors: write then read back on cdata_rd and dbg.
    for (int i = 0; i < 8; i++) begin
      bank_write(bvec[i].sel, bvec[i].addr, bvec[i].data);
      bank_read(bvec[i].sel, bvec[i].addr, q);
      check($sformatf("bank_rd_s%0d_a%0d", bvec[i].sel, bvec[i].addr), q, bvec[i].exp);
      dbg_check($sformatf("bank_dbg_s%0d_a%0d", bvec[i].sel, bvec[i].addr),
                bvec[i].sel, bvec[i].addr, bvec[i].exp);
    end
    check("no_errs_after_valid", {err_sel, err_addr}, 0);

    // Out-of-range address on the 1024-word bank: dropped, err_addr raised.
    cyc();
    bank_write(3'd3, 12'd1024, 20'h77777);
    check("oob_err_addr", err_addr, 1);
    check("oob_err_sel_clear", err_sel, 0);
    dbg_check("oob_no_alias", 3'd3, 12'd0, 20'h00ABC);
    dbg_check("oob_top_intact", 3'd3, 12'd1023, 20'h12345);

    // Read-before-write on the same address in one cycle.
    cyc();
    bank_write(3'd5, 12'd7, 20'hAAAAA);
    csel = 3'd5; caddr_wr = 12'd7; cdata_wr = 20'h55555; cwr = 1'b1;
    caddr_rd = 12'd7; crd = 1'b1;
    cyc();
    cwr = 1'b0; crd = 1'b0;
    @(negedge clk);
    #1;
    check("rbw_old_value", cdata_rd, 20'hAAAAA);
    dbg_check("rbw_new_value", 3'd5, 12'd7, 20'h55555);

    // Unmapped select: no bank changes, err_sel raised; reads of it return zero.
    cyc();
    bank_write(3'd6, 12'd7, 20'h11111);
    check("bad_sel_err", err_sel, 1);
    for (int i = 0; i < 8; i++)
      dbg_check($sformatf("sweep_s%0d_a%0d", bvec[i].sel, bvec[i].addr),
                bvec[i].sel, bvec[i].addr, bvec[i].exp);
    dbg_check("sweep_l2_a7", 3'd5, 12'd7, 20'h55555);
    dbg_check("dbg_sel0_zero", 3'd0, 12'd0, 20'h0);
    dbg_check("dbg_oob_zero", 3'd4, 12'd1024, 20'h0);
    bank_read(3'd0, 12'd0, q);
    check("bad_sel_read_zero", q, 0);

    // Load and start together in IDLE: the load lands and the run arms.
    cyc();
    load_en = 1'b1; load_addr = 12'd5; load_data = 20'hFFFFF; start = 1'b1;
    cyc();
    load_en = 1'b0; start = 1'b0;
    check("load_start_ready", ready, 1);
    iaddr = 12'd5;
    @(negedge clk);
    #1;
    check("load_start_img", idata, 20'hFFFFF);
    busy = 1'b1;
    cyc();
    busy = 1'b0;
    cyc();
    cyc();

    // Arm timeout with busy held low.
    pulse_start();
    check("to_armed", ready, 1);
    repeat (TIMEOUT - 1) cyc();
    check("to_not_yet", err_timeout, 0);
    check("to_ready_still", ready, 1);
    cyc();
    check("to_err", err_timeout, 1);
    check("to_ready_low", ready, 0);

    // Reset while armed clears the sticky flags and ready.
    pulse_start();
    reset = 1'b0;
    cyc();
    reset = 1'b1;
    check("rst_arm_ready", ready, 0);
    check("rst_errs_clear", {err_sel, err_addr, err_timeout}, 0);

    // Reset mid-run: abort without a done pulse, storage intact.
    pulse_start();
    busy = 1'b1;
    cyc();
    check("mid_run_ready", ready, 0);
    reset = 1'b0;
    cyc();
    reset = 1'b1;
    busy  = 1'b0;
    pulses = 0;
    for (int k = 0; k < 6; k++) begin
      cyc();
      if (done) pulses++;
    end
    check("mid_run_no_done", pulses, 0);
    check("mid_run_ready_after", ready, 0);
    iaddr = 12'd123;
    @(negedge clk);
    #1;
    check("img_intact", idata, 20'd123);
    dbg_check("bank_intact", 3'd3, 12'd1023, 20'h12345);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
